// File: rtl/mad_irq_controller.sv
// Interrupt request controller: edge-captured pending register, per-source mask,
// fixed-priority grant with a programmed Int pulse and hold-off window.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on every Irq line.
module mad_irq_controller #(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned PULSE_LEN = 1,
   parameter int unsigned HOLDOFF   = 8
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [NUM_SRC-1:0] Irq,
   input  logic [NUM_SRC-1:0] Mask,
   output logic               Int,
   output logic [2:0]         Vector,
   output logic [NUM_SRC-1:0] Pending,
   output logic               Busy
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned VEC_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      HOLD
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               int_nxt;
   logic [VEC_W-1:0]   vec_nxt;
   logic [NUM_SRC-1:0] pend_nxt;
   logic [NUM_SRC-1:0] irq_s;
   logic [NUM_SRC-1:0] irq_prev;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] eligible;
   logic               found;

`ifdef IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync_1;
   logic [NUM_SRC-1:0] sync_2;

   // Two-stage synchronizer for lines asynchronous to Clk
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= Irq;
         sync_2 <= sync_1;
      end
   end

   assign irq_s = sync_2;
`else
   assign irq_s = Irq;
`endif

   // irq_prev also tracks during reset so a line held high at release is not an edge
   always_ff @(posedge Clk) begin
      irq_prev <= irq_s;
   end

   assign rise     = irq_s & ~irq_prev;
   assign eligible = Pending & Mask;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      int_nxt   = Int;
      vec_nxt   = Vector;
      grant     = '0;
      found     = 1'b0;

      case (state)
         IDLE: begin
            int_nxt = 1'b0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
               if (!found && eligible[i]) begin
                  found    = 1'b1;
                  grant[i] = 1'b1;
                  vec_nxt  = VEC_W'(i);
               end
            end
            if (found) begin
               int_nxt   = 1'b1;
               cnt_nxt   = CNT_W'(PULSE_LEN - 1);
               state_nxt = ASSERT;
            end
         end
         ASSERT: begin
            int_nxt = 1'b1;
            if (cnt == '0) begin
               int_nxt = 1'b0;
               if (HOLDOFF != 0) begin
                  cnt_nxt   = CNT_W'(HOLDOFF - 1);
                  state_nxt = HOLD;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         HOLD: begin
            int_nxt = 1'b0;
            if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            int_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase

      // A fresh rise on the granted bit wins over its clear
      pend_nxt = (Pending & ~grant) | rise;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= IDLE;
         cnt     <= '0;
         Int     <= 1'b0;
         Vector  <= '0;
         Pending <= '0;
         Busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         Int     <= int_nxt;
         Vector  <= vec_nxt;
         Pending <= pend_nxt;
         Busy    <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_mad_irq_controller.sv
// Directed bench for mad_irq_controller: default build, three parameter sets
// (defaults, PULSE_LEN=1/HOLDOFF=0, PULSE_LEN=4/HOLDOFF=8).
module tb_mad_irq_controller;

   logic       clk = 1'b0;
   int         checks = 0;
   int         errors = 0;

   logic       rst_a, rst_b, rst_c;
   logic [3:0] irq_a, irq_b, irq_c;
   logic [3:0] mask_a, mask_b, mask_c;
   logic       int_a, int_b, int_c;
   logic [2:0] vec_a, vec_b, vec_c;
   logic [3:0] pend_a, pend_b, pend_c;
   logic       busy_a, busy_b, busy_c;

   always #5 clk = ~clk;

   mad_irq_controller #(.NUM_SRC(4), .PULSE_LEN(1), .HOLDOFF(8)) dut_a (
      .Clk(clk), .Rst(rst_a), .Irq(irq_a), .Mask(mask_a),
      .Int(int_a), .Vector(vec_a), .Pending(pend_a), .Busy(busy_a)
   );

   mad_irq_controller #(.NUM_SRC(4), .PULSE_LEN(1), .HOLDOFF(0)) dut_b (
      .Clk(clk), .Rst(rst_b), .Irq(irq_b), .Mask(mask_b),
      .Int(int_b), .Vector(vec_b), .Pending(pend_b), .Busy(busy_b)
   );

   mad_irq_controller #(.NUM_SRC(4), .PULSE_LEN(4), .HOLDOFF(8)) dut_c (
      .Clk(clk), .Rst(rst_c), .Irq(irq_c), .Mask(mask_c),
      .Int(int_c), .Vector(vec_c), .Pending(pend_c), .Busy(busy_c)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; irq_a = 4'b0001; mask_a = 4'hF;
      for (int k = 0; k < 3; k++) step();
      checks++;
      if ({int_a, busy_a, vec_a, pend_a} !== 9'b0) begin
         errors++;
         $display("FAIL reset_state: Int=%b Busy=%b Vector=%0d Pending=%b, want all 0",
                  int_a, busy_a, vec_a, pend_a);
      end
      rst_a = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (int_a !== 1'b0 || pend_a !== 4'b0000 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_edge: cycle %0d Int=%b Pending=%b Busy=%b, want 0/0000/0",
                     k, int_a, pend_a, busy_a);
         end
      end
      irq_a = 4'b0000;
      step();
   endtask

   task automatic test_single_grant();
      irq_a = 4'b0100;
      step();
      checks++;
      if (pend_a !== 4'b0100 || int_a !== 1'b0) begin
         errors++;
         $display("FAIL single_pending: Pending=%b Int=%b, want 0100/0", pend_a, int_a);
      end
      step();
      checks++;
      if (int_a !== 1'b1 || vec_a !== 3'd2 || pend_a !== 4'b0000 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: Int=%b Vector=%0d Pending=%b Busy=%b, want 1/2/0000/1",
                  int_a, vec_a, pend_a, busy_a);
      end
      irq_a = 4'b0000;
      step();
      checks++;
      if (int_a !== 1'b0 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL single_pulse_end: Int=%b Busy=%b, want 0/1", int_a, busy_a);
      end
      for (int k = 13; k <= 19; k++) begin
         step();
         checks++;
         if (busy_a !== 1'b1 || int_a !== 1'b0) begin
            errors++;
            $display("FAIL single_holdoff: edge %0d Busy=%b Int=%b, want 1/0", k, busy_a, int_a);
         end
      end
      step();
      checks++;
      if (busy_a !== 1'b0 || vec_a !== 3'd2) begin
         errors++;
         $display("FAIL single_idle: Busy=%b Vector=%0d, want 0/2", busy_a, vec_a);
      end
   endtask

   task automatic test_priority();
      int      n_rise;
      int      t_rise [2];
      logic [2:0] v_rise [2];
      logic    prev_int;
      int      t;
      n_rise = 0; prev_int = 1'b0; t = 0;
      t_rise[0] = 0; t_rise[1] = 0; v_rise[0] = '0; v_rise[1] = '0;
      irq_a = 4'b1010;
      step();
      checks++;
      if (pend_a !== 4'b1010) begin
         errors++;
         $display("FAIL prio_pending: Pending=%b, want 1010", pend_a);
      end
      irq_a = 4'b0000;
      for (int k = 0; k < 40; k++) begin
         step();
         t++;
         if (int_a && !prev_int) begin
            if (n_rise < 2) begin
               t_rise[n_rise] = t;
               v_rise[n_rise] = vec_a;
            end
            n_rise++;
         end
         prev_int = int_a;
      end
      checks++;
      if (n_rise !== 2) begin
         errors++;
         $display("FAIL prio_count: %0d Int pulses, want 2", n_rise);
      end
      checks++;
      if (v_rise[0] !== 3'd1 || v_rise[1] !== 3'd3) begin
         errors++;
         $display("FAIL prio_order: Vectors %0d,%0d, want 1,3", v_rise[0], v_rise[1]);
      end
      checks++;
      if (t_rise[1] - t_rise[0] !== 10) begin
         errors++;
         $display("FAIL prio_spacing: %0d cycles, want 10", t_rise[1] - t_rise[0]);
      end
      checks++;
      if (busy_a !== 1'b0 || pend_a !== 4'b0000) begin
         errors++;
         $display("FAIL prio_drain: Busy=%b Pending=%b, want 0/0000", busy_a, pend_a);
      end
   endtask

   task automatic test_masked();
      mask_a = 4'b1110;
      irq_a  = 4'b0001;
      step();
      irq_a = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (pend_a !== 4'b0001 || int_a !== 1'b0 || vec_a !== 3'd3) begin
            errors++;
            $display("FAIL masked_hold: Pending=%b Int=%b Vector=%0d, want 0001/0/3",
                     pend_a, int_a, vec_a);
         end
      end
      mask_a = 4'hF;
      step();
      checks++;
      if (int_a !== 1'b1 || vec_a !== 3'd0 || pend_a !== 4'b0000) begin
         errors++;
         $display("FAIL masked_unmask: Int=%b Vector=%0d Pending=%b, want 1/0/0000",
                  int_a, vec_a, pend_a);
      end
      for (int k = 0; k < 10; k++) step();
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL masked_idle: Busy=%b, want 0", busy_a);
      end
   endtask

   task automatic test_set_wins();
      rst_b = 1'b1; irq_b = 4'b0000; mask_b = 4'b1101;
      step();
      rst_b = 1'b0;
      irq_b = 4'b0010;
      step();
      irq_b = 4'b0000;
      step();
      checks++;
      if (pend_b !== 4'b0010 || int_b !== 1'b0) begin
         errors++;
         $display("FAIL setwins_pending: Pending=%b Int=%b, want 0010/0", pend_b, int_b);
      end
      mask_b = 4'hF;
      irq_b  = 4'b0010;
      step();
      checks++;
      if (int_b !== 1'b1 || vec_b !== 3'd1 || pend_b !== 4'b0010) begin
         errors++;
         $display("FAIL setwins_first: Int=%b Vector=%0d Pending=%b, want 1/1/0010",
                  int_b, vec_b, pend_b);
      end
      irq_b = 4'b0000;
      step();
      checks++;
      if (int_b !== 1'b0 || busy_b !== 1'b0 || pend_b !== 4'b0010) begin
         errors++;
         $display("FAIL setwins_gap: Int=%b Busy=%b Pending=%b, want 0/0/0010",
                  int_b, busy_b, pend_b);
      end
      step();
      checks++;
      if (int_b !== 1'b1 || vec_b !== 3'd1 || pend_b !== 4'b0000) begin
         errors++;
         $display("FAIL setwins_second: Int=%b Vector=%0d Pending=%b, want 1/1/0000",
                  int_b, vec_b, pend_b);
      end
      step();
      checks++;
      if (int_b !== 1'b0) begin
         errors++;
         $display("FAIL setwins_end: Int=%b, want 0", int_b);
      end
   endtask

   task automatic test_reset_mid();
      rst_c = 1'b1; irq_c = 4'b0000; mask_c = 4'hF;
      step();
      rst_c = 1'b0;
      irq_c = 4'b0001;
      step();
      irq_c = 4'b0101;
      step();
      checks++;
      if (int_c !== 1'b1 || vec_c !== 3'd0 || pend_c !== 4'b0100) begin
         errors++;
         $display("FAIL rmid_pulse1: Int=%b Vector=%0d Pending=%b, want 1/0/0100",
                  int_c, vec_c, pend_c);
      end
      step();
      checks++;
      if (int_c !== 1'b1 || busy_c !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pulse2: Int=%b Busy=%b, want 1/1", int_c, busy_c);
      end
      rst_c = 1'b1;
      step();
      checks++;
      if (int_c !== 1'b0 || busy_c !== 1'b0 || pend_c !== 4'b0000 || vec_c !== 3'd0) begin
         errors++;
         $display("FAIL rmid_abort: Int=%b Busy=%b Pending=%b Vector=%0d, want 0/0/0000/0",
                  int_c, busy_c, pend_c, vec_c);
      end
      rst_c = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (int_c !== 1'b0 || pend_c !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_after: cycle %0d Int=%b Pending=%b, want 0/0000",
                     k, int_c, pend_c);
         end
      end
   endtask

   initial begin
      rst_a = 1'b1; irq_a = '0; mask_a = '0;
      rst_b = 1'b1; irq_b = '0; mask_b = '0;
      rst_c = 1'b1; irq_c = '0; mask_c = '0;
      test_reset();
      test_single_grant();
      test_priority();
      test_masked();
      test_set_wins();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
